// File: rtl/ca_line_engine.sv
// One-row elementary cellular automaton engine over a double-buffered 160x16 line RAM.
// Optional feature: define WRAP_EDGES_EN for a toroidal row (otherwise out-of-row cells are 0).
module ca_line_engine #(
  parameter int unsigned WORDS     = 80,
  parameter int unsigned HALF_BASE = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        src_half,
  input  logic [7:0]  rule,
  input  logic        disp_read,
  input  logic [7:0]  disp_addr,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LastIdx  = 8'(WORDS - 1);
  localparam logic [7:0] HalfBase = 8'(HALF_BASE);

  typedef enum logic [3:0] {
    StIdle,
`ifdef WRAP_EDGES_EN
    StPrimeL,
    StCapL,
`endif
    StPrimeC,
    StCapC,
    StFetch,
    StCapN,
    StWrite,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  rule_q, rule_d;
  logic        src_half_q, src_half_d;
  logic        lbit_q, lbit_d;
  logic [15:0] cur_q, cur_d;
  logic [15:0] next_q, next_d;
`ifdef WRAP_EDGES_EN
  logic        first15_q, first15_d;
`endif

  logic [7:0]  src_base, dst_base;
  logic [17:0] ext;
  logic [15:0] new_word;

  assign src_base = src_half_q ? HalfBase : 8'd0;
  assign dst_base = src_half_q ? 8'd0 : HalfBase;

  // ext[b+2:b] is the {L,C,R} neighbourhood of cur bit b
  assign ext = {lbit_q, cur_q, next_q[15]};

  always_comb begin
    new_word = '0;
    for (int b = 0; b < 16; b++) begin
      new_word[b] = rule_q[ext[b +: 3]];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rule_d     = rule_q;
    src_half_d = src_half_q;
    lbit_d     = lbit_q;
    cur_d      = cur_q;
    next_d     = next_q;
`ifdef WRAP_EDGES_EN
    first15_d  = first15_q;
`endif
    ram_addr   = 8'd0;
    ram_we     = 1'b0;
    ram_wdata  = 16'd0;

    // Capture states never stall: their data was returned by the previous granted read.
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rule_d     = rule;
          src_half_d = src_half;
          idx_d      = 8'd0;
          lbit_d     = 1'b0;
`ifdef WRAP_EDGES_EN
          state_d    = StPrimeL;
`else
          state_d    = StPrimeC;
`endif
        end
      end
`ifdef WRAP_EDGES_EN
      StPrimeL: begin
        if (!disp_read) begin
          ram_addr = src_base + LastIdx;
          state_d  = StCapL;
        end
      end
      StCapL: begin
        lbit_d  = ram_rdata[0];
        state_d = StPrimeC;
      end
`endif
      StPrimeC: begin
        if (!disp_read) begin
          ram_addr = src_base;
          state_d  = StCapC;
        end
      end
      StCapC: begin
        cur_d     = ram_rdata;
`ifdef WRAP_EDGES_EN
        first15_d = ram_rdata[15];
`endif
        state_d   = StFetch;
      end
      StFetch: begin
        if (!disp_read) begin
          if (idx_q < LastIdx) begin
            ram_addr = src_base + idx_q + 8'd1;
            state_d  = StCapN;
          end else begin
`ifdef WRAP_EDGES_EN
            next_d = {first15_q, 15'd0};
`else
            next_d = 16'd0;
`endif
            state_d = StWrite;
          end
        end
      end
      StCapN: begin
        next_d  = ram_rdata;
        state_d = StWrite;
      end
      StWrite: begin
        if (!disp_read) begin
          ram_we    = 1'b1;
          ram_addr  = dst_base + idx_q;
          ram_wdata = new_word;
          lbit_d    = cur_q[0];
          cur_d     = next_q;
          idx_d     = idx_q + 8'd1;
          state_d   = (idx_q == LastIdx) ? StDone : StFetch;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (disp_read) begin
      ram_addr = disp_addr;
      ram_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= 8'd0;
      rule_q     <= 8'd0;
      src_half_q <= 1'b0;
      lbit_q     <= 1'b0;
      cur_q      <= 16'd0;
      next_q     <= 16'd0;
`ifdef WRAP_EDGES_EN
      first15_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rule_q     <= rule_d;
      src_half_q <= src_half_d;
      lbit_q     <= lbit_d;
      cur_q      <= cur_d;
      next_q     <= next_d;
`ifdef WRAP_EDGES_EN
      first15_q  <= first15_d;
`endif
    end
  end

  assign busy = (state_q != StIdle) && (state_q != StDone);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_ca_line_engine.sv
// Directed bench for ca_line_engine: RAM model, pixel-level reference row model and write scoreboard.
module tb_ca_line_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        src_half = 1'b0;
  logic [7:0]  rule = 8'd0;
  logic        disp_read = 1'b0;
  logic [7:0]  disp_addr = 8'd0;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'd0;
  logic        busy;
  logic        done;

  ca_line_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_half  (src_half),
    .rule      (rule),
    .disp_read (disp_read),
    .disp_addr (disp_addr),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] mem [160];
  logic [15:0] saved [160];
  wr_t         exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  int          cyc = 0;
  int          stall_base = 0;
  bit          stall_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-port RAM, registered read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_addr < 8'd160) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end else begin
      ram_rdata <= 16'hdead;
    end
  end

  // Monitor: arbitration rules, write scoreboard, done counting
  always @(negedge clk) begin
    if (rst_n) begin
      if (disp_read) begin
        check("arb_we", 32'(ram_we), 32'd0);
        check("arb_addr", 32'(ram_addr), 32'(disp_addr));
      end
      if (ram_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(ram_addr), 32'hffff_ffff);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(e.addr));
          check("wr_data", 32'(ram_wdata), 32'(e.data));
        end
      end
      if (done) done_cnt++;
    end
  end

  // Display prefetch stand-in: every 16th cycle plus a 5-cycle burst mid-row
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        disp_read = ((cyc % 16) == 0) ||
                    ((cyc - stall_base) >= 100 && (cyc - stall_base) < 105);
        disp_addr = 8'($urandom_range(0, 159));
      end else begin
        disp_read = 1'b0;
      end
    end
  end

  task automatic push_expected(input logic sh, input logic [7:0] rl);
    logic [1279:0] row;
    logic [1279:0] nrow;
    logic          l, c, r;
    wr_t           e;
    int            sb, db;
    sb = sh ? 80 : 0;
    db = sh ? 0 : 80;
    for (int w = 0; w < 80; w++)
      for (int b = 0; b < 16; b++) row[w * 16 + (15 - b)] = mem[sb + w][b];
    for (int p = 0; p < 1280; p++) begin
      c = row[p];
`ifdef WRAP_EDGES_EN
      if (p == 0) l = row[1279]; else l = row[p - 1];
      if (p == 1279) r = row[0]; else r = row[p + 1];
`else
      if (p == 0) l = 1'b0; else l = row[p - 1];
      if (p == 1279) r = 1'b0; else r = row[p + 1];
`endif
      nrow[p] = rl[{l, c, r}];
    end
    for (int w = 0; w < 80; w++) begin
      e.addr = 8'(db + w);
      for (int b = 0; b < 16; b++) e.data[15 - b] = nrow[w * 16 + b];
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic sh, input logic [7:0] rl);
    start = 1'b1;
    src_half = sh;
    rule = rl;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_row(input string tag, input logic sh, input logic [7:0] rl,
                         input bit stall, input bit restart);
    int n;
    push_expected(sh, rl);
    done_cnt = 0;
    @(posedge clk);
    #1;
    if (stall) begin
      while ((cyc % 16) != 0) begin
        @(posedge clk);
        #1;
      end
      stall_base = cyc;
      stall_en = 1'b1;
    end
    pulse_start(sh, rl);
    if (restart) begin
      repeat (20) @(posedge clk);
      #1;
      pulse_start(~sh, ~rl);
    end
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(done_cnt > 0), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    stall_en = 1'b0;
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic load_single(input int w, input logic [15:0] v);
    for (int i = 0; i < 160; i++) mem[i] = 16'd0;
    mem[w] = v;
  endtask

  initial begin
    int wr_before;
    for (int i = 0; i < 160; i++) mem[i] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Rule 30 from a single set pixel
    load_single(39, 16'h0001);
    run_row("r30", 1'b0, 8'd30, 1'b0, 1'b0);
    check("r30_w39", 32'(mem[80 + 39]), 32'h0003);
    check("r30_w40", 32'(mem[80 + 40]), 32'h8000);
    check("r30_w38", 32'(mem[80 + 38]), 32'h0000);

    // Same row under display stalls
    load_single(39, 16'h0001);
    for (int i = 80; i < 160; i++) mem[i] = 16'hffff;
    run_row("stall", 1'b0, 8'd30, 1'b1, 1'b0);
    check("stall_w39", 32'(mem[80 + 39]), 32'h0003);
    check("stall_w40", 32'(mem[80 + 40]), 32'h8000);
    check("stall_w0", 32'(mem[80]), 32'h0000);

    // Edge handling with rule 90
    load_single(0, 16'h8000);
    run_row("r90", 1'b0, 8'd90, 1'b0, 1'b0);
    check("r90_w0", 32'(mem[80]), 32'h4000);
`ifdef WRAP_EDGES_EN
    check("r90_w79", 32'(mem[80 + 79]), 32'h0001);
`else
    check("r90_w79", 32'(mem[80 + 79]), 32'h0000);
`endif

    // Identity copy from half 1 to half 0, with a second start while busy
    for (int i = 0; i < 160; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 160; i++) saved[i] = mem[i];
    run_row("copy", 1'b1, 8'd204, 1'b0, 1'b1);
    begin
      int bad_lo, bad_hi;
      bad_lo = 0;
      bad_hi = 0;
      for (int i = 0; i < 80; i++) if (mem[i] !== saved[80 + i]) bad_lo++;
      for (int i = 80; i < 160; i++) if (mem[i] !== saved[i]) bad_hi++;
      check("copy_lo_mismatches", 32'(bad_lo), 32'd0);
      check("copy_hi_touched", 32'(bad_hi), 32'd0);
    end

    // Reset mid-row aborts without further writes
    load_single(39, 16'h0001);
    push_expected(1'b0, 8'd30);
    done_cnt = 0;
    pulse_start(1'b0, 8'd30);
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_we", 32'(ram_we), 32'd0);
    check("abort_addr", 32'(ram_addr), 32'd0);
    check("abort_wdata", 32'(ram_wdata), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    wr_before = wr_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("abort_no_writes", 32'(wr_cnt - wr_before), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // Normal run after the abort
    load_single(39, 16'h0001);
    run_row("post", 1'b0, 8'd30, 1'b0, 1'b0);
    check("post_w39", 32'(mem[80 + 39]), 32'h0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ca_line_engine.md
Name: ca_line_engine

Overview:
- Computes the next generation of a 1-D elementary cellular automaton, one scanline at a time.
- Reads the displayed half of the 160x16 line RAM and writes the new row into the other half.
- Shares the single-port RAM with the display prefetch reader; the display always wins.
- Sits between the VGA timing/prefetch logic and the line RAM, and is started once per scanline.

Parameters:
- WORDS, 80, 16-bit words per line (1280 pixels).
- HALF_BASE, 80, address offset of half 1; half 0 spans 0..WORDS-1.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin computing one row
- src_half  in  1  half holding the current row; the destination is the other half
- rule  in  8  Wolfram rule number
- disp_read  in  1  display prefetch read request for this cycle
- disp_addr  in  8  display read address
- ram_addr  out  8  line RAM address
- ram_we  out  1  line RAM write enable
- ram_wdata  out  16  line RAM write data
- ram_rdata  in  16  line RAM read data, valid 1 cycle after address
- busy  out  1  row computation in progress
- done  out  1  one-cycle pulse when the last word is written

Behaviour:
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, busy=0, done=0, FSM=IDLE, idx=0.
- Reset asserted mid-row aborts immediately. No further writes are made; the partial destination row is left as is.
- Arbitration:
  - When disp_read=1: ram_addr=disp_addr, ram_we=0, and the engine stalls in its current state with all registers held.
  - Otherwise the engine drives the RAM.
  - The engine captures ram_rdata only in the cycle after its own granted read. Data returned for a display read is never captured.
- Bit order: bit 15 is the leftmost pixel of a word; word 0 is the leftmost word.
- Cell update: new[b] = rule[{L,C,R}].
  - C = cur[b]; L = bit to its left; R = bit to its right.
  - For b=15, L = previous word bit 0. For b=0, R = next word bit 15.
- FSM states:
  - IDLE: on start, latch rule and src_half, set idx=0, set busy=1, go to PRIME_L. start while busy is ignored.
  - PRIME_L: read src word WORDS-1. On capture, lbit=word[0] and go to PRIME_C. With edges off, lbit=0 and this state is skipped with no read.
  - PRIME_C: read src word 0. On capture, cur=word and first15=word[15].
  - FETCH: if idx<WORDS-1, read src word idx+1 and capture next. If idx==WORDS-1, set next[15]=first15 (wrap) or 0 (edges off) without a read.
  - WRITE: ram_we=1, address = dst base + idx, wdata = computed word. Then lbit=cur[0], cur=next, idx++. If the written idx was WORDS-1, go to DONE; else go to FETCH.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Source address = src_half ? HALF_BASE+i : i. Destination uses !src_half.
- Unstalled cost is 3 cycles per word plus priming, about 245 cycles per row. This fits comfortably in a 1280-pixel line with 1 display read per 16 cycles.
- A read issue and its capture cycle are separate states. A display read landing in the capture cycle does not corrupt capture, because the engine's data was already returned.
- Simultaneous start and disp_read: start is latched, and the first engine access waits.

Optional Feature:
- Macro WRAP_EDGES_EN.
- Defined: toroidal row. The left neighbour of pixel 0 is pixel 1279, and the right neighbour of pixel 1279 is pixel 0. PRIME_L is present.
- Undefined: cells outside the row read as 0. PRIME_L is removed; each row takes 2 fewer cycles with no stalls.

Test Plan:
- Rule 30, no stalls, src_half=0, word 39 = 16'h0001, all other words 0:
  - Half 1 word 39 = 16'h0003 and word 40 = 16'h8000; all other words 0.
  - done pulses exactly once; busy is low afterwards.
- Stall: disp_read asserted every 16th cycle plus 5 consecutive cycles mid-row:
  - Result is bit-identical to the no-stall run.
  - ram_we is never 1 while disp_read=1, and ram_addr always equals disp_addr in those cycles.
- Edge wrap, rule 90 (left XOR right), src word 0 = 16'h8000, src word 79 = 0:
  - With WRAP_EDGES_EN: dst word 0 = 16'h4000 and dst word 79 = 16'h0001.
  - Without WRAP_EDGES_EN: dst word 79 = 0.
- src_half=1 with rule 204 (identity): half 0 becomes a copy of half 1. No write lands in 80..159.
- start pulsed again while busy: ignored, with exactly one done. Then rst_n low for 1 cycle mid-row: outputs return to reset values at once with no further writes, and the next start runs normally.
